writeback: RTL
==============

// Module: writeback
// PURPOSE
//   Commit stage directly downstream of the execute stage. Consumes the execute
//   result (wselector, rd, data, pc target, stall flag) on each done pulse.
//   Writes the integer or float register file and advances or redirects the PC.
//   Serves the decode stage's two combinational operand read ports.
// PARAMETERS
//   RESET_PC     32'h0  PC value loaded on reset
//   RETIRE_W     32     width of the retired-instruction counter
// PORTS
//   clk           in   1         clock, rising edge
//   rstn          in   1         asynchronous active-low reset
//   enable        in   1         1-cycle pulse: execute result valid (execute done)
//   wselector     in   3         [2] PC redirect, [1] register write, [0] float file
//   rd            in   5         destination register number
//   data          in   32        write data
//   pc_target     in   32        redirect target (execute pc_out)
//   stall_enable  in   1         execute refused the instruction; re-issue same PC
//   done          out  1         1-cycle pulse: commit finished, pc valid for fetch
//   pc            out  32        PC of next instruction to fetch
//   rs_no, rt_no  in   5 each    read addresses
//   fmode1        in   1         1: rs read from the float file, 0: from the integer file
//   fmode2        in   1         1: rt read from the float file, 0: from the integer file
//   rs, rt        out  32 each   read data (combinational)
//   retire_count  out  RETIRE_W  committed (non-stalled) instruction count
//   misalign      out  1         sticky: a redirect target had nonzero bits [1:0]
// BEHAVIOUR
// - Reset (async, rstn=0): pc=RESET_PC, done=0, retire_count=0, misalign=0.
//   All 64 registers clear to 0. Reset mid-commit discards that commit.
// - Latency: done asserts exactly 1 cycle after enable. The PC and register
//   updates take effect on that same edge. Back-to-back enable pulses every
//   cycle are legal.
// - Each enable edge is one of three cases:
//   * stall_enable=1: no register write; pc unchanged; retire_count unchanged;
//     done=1. wselector is ignored.
//   * wselector[2]=1: pc <= {pc_target[31:2],2'b00}. If pc_target[1:0]!=0,
//     misalign <= 1.
//   * otherwise: pc <= pc+4, wrapping 32'hFFFFFFFC -> 0.
//   retire_count increments on every non-stalled enable and wraps at 2^RETIRE_W.
// - Register write occurs when enable && !stall_enable && wselector[1].
//   * wselector[0]=1: float[rd] <= data. Float register 0 is writable.
//   * wselector[0]=0: int[rd] <= data, except rd=0, which is ignored.
//   * wselector 3'b110 (jump-and-link): writes int[rd] and redirects pc in the same cycle.
//   * wselector=3'b000 with enable (stores, uart out): only the pc and the counter are updated.
// - Read ports: rs = fmode1 ? float[rs_no] : int[rs_no]; rt is the same using
//   fmode2/rt_no. int[0] always reads 0.
//   Write-first bypass: if a write is committing this cycle to the same file and
//   number, the port returns the incoming data.
//   A write to int[0] is never bypassed.
// - Outputs with enable=0: done=0; all state holds.
// - Inputs other than rs_no/rt_no/fmode* are sampled only when enable=1.
// TESTING
// 1. Reset release: pc=RESET_PC, rs/rt=0 for every address in both files, retire_count=0.
// 2. enable, wsel=010, rd=5, data=32'h1234 -> next cycle done=1, int[5]=32'h1234,
//    pc+=4. In the same cycle, rs_no=5/fmode1=0 reads 32'h1234 (bypass).
//    Then wsel=011, rd=5, data=32'h3F800000 -> float[5] written, int[5] unchanged.
// 3. wsel=010, rd=0, data=32'hFFFFFFFF -> int[0] reads 0, also during the bypass
//    cycle. wsel=011, rd=0 -> float[0] reads 32'hFFFFFFFF.
// 4. pc=32'h100, wsel=110, rd=31, data=32'h104, pc_target=32'h2002
//    -> pc=32'h2000, misalign=1, int[31]=32'h104, retire_count+1.
// 5. stall_enable=1 with wsel=010, rd=3 -> int[3] unchanged, pc unchanged,
//    done=1, retire_count unchanged.
// 6. 4 consecutive enable cycles from pc=32'hFFFFFFF8 -> pc sequence FFFFFFFC, 0, 4, 8.
//    Asserting rstn=0 mid-sequence -> immediate pc=RESET_PC, done=0.

Source files
------------

// File: rtl/writeback_if.sv
// Commit-stage bundle: execute result in, fetch PC / status out, plus the two
// decode operand read ports.
interface writeback_if #(
  parameter int unsigned RETIRE_W = 32
);
  logic                enable;
  logic [2:0]          wselector;
  logic [4:0]          rd;
  logic [31:0]         data;
  logic [31:0]         pc_target;
  logic                stall_enable;
  logic                done;
  logic [31:0]         pc;
  logic [4:0]          rs_no;
  logic [4:0]          rt_no;
  logic                fmode1;
  logic                fmode2;
  logic [31:0]         rs;
  logic [31:0]         rt;
  logic [RETIRE_W-1:0] retire_count;
  logic                misalign;

  modport master (
    output enable, wselector, rd, data, pc_target, stall_enable,
    output rs_no, rt_no, fmode1, fmode2,
    input  done, pc, rs, rt, retire_count, misalign
  );

  modport slave (
    input  enable, wselector, rd, data, pc_target, stall_enable,
    input  rs_no, rt_no, fmode1, fmode2,
    output done, pc, rs, rt, retire_count, misalign
  );
endinterface

// File: rtl/writeback.sv
// Commit stage: writes the integer/float register files, advances or redirects
// the PC, and serves two combinational operand read ports with write-first bypass.
module writeback #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned RETIRE_W = 32
) (
  input logic         clk,
  input logic         rstn,
  writeback_if.slave  wb
);

  logic [31:0]         int_q [32];
  logic [31:0]         int_d [32];
  logic [31:0]         flt_q [32];
  logic [31:0]         flt_d [32];
  logic [31:0]         pc_q, pc_d;
  logic                done_q, done_d;
  logic                misalign_q, misalign_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;

  logic commit, wr_int, wr_flt;

  assign commit = wb.enable & ~wb.stall_enable;
  // int[0] is hardwired zero, so a write to it is dropped here and never bypassed.
  assign wr_int = commit & wb.wselector[1] & ~wb.wselector[0] & (wb.rd != 5'd0);
  assign wr_flt = commit & wb.wselector[1] & wb.wselector[0];

  always_comb begin
    int_d      = int_q;
    flt_d      = flt_q;
    pc_d       = pc_q;
    done_d     = wb.enable;
    misalign_d = misalign_q;
    retire_d   = retire_q;
    if (wr_int) int_d[wb.rd] = wb.data;
    if (wr_flt) flt_d[wb.rd] = wb.data;
    if (commit) begin
      retire_d = retire_q + RETIRE_W'(1);
      if (wb.wselector[2]) begin
        pc_d = {wb.pc_target[31:2], 2'b00};
        if (wb.pc_target[1:0] != 2'b00) misalign_d = 1'b1;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) begin
        int_q[i] <= 32'h0;
        flt_q[i] <= 32'h0;
      end
      pc_q       <= RESET_PC;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      retire_q   <= '0;
    end else begin
      int_q      <= int_d;
      flt_q      <= flt_d;
      pc_q       <= pc_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
      retire_q   <= retire_d;
    end
  end

  always_comb begin
    wb.rs = 32'h0;
    if (wb.fmode1) begin
      wb.rs = (wr_flt && wb.rd == wb.rs_no) ? wb.data : flt_q[wb.rs_no];
    end else if (wb.rs_no != 5'd0) begin
      wb.rs = (wr_int && wb.rd == wb.rs_no) ? wb.data : int_q[wb.rs_no];
    end
  end

  always_comb begin
    wb.rt = 32'h0;
    if (wb.fmode2) begin
      wb.rt = (wr_flt && wb.rd == wb.rt_no) ? wb.data : flt_q[wb.rt_no];
    end else if (wb.rt_no != 5'd0) begin
      wb.rt = (wr_int && wb.rd == wb.rt_no) ? wb.data : int_q[wb.rt_no];
    end
  end

  assign wb.done         = done_q;
  assign wb.pc           = pc_q;
  assign wb.misalign     = misalign_q;
  assign wb.retire_count = retire_q;

endmodule
